mem_access_ctrl: RTL

Memory-stage access controller for the pipelined MIPS core. Consumes the EX/MEM latch outputs, drives the datapath-side dcache request (dmemREN/dmemWEN/dmemaddr/dmemstore), and stalls the pipeline until dhit. It holds completed load data until the MEM/WB latch advances and owns the per-core LL/SC link register, including snoop invalidation from the coherence controller.

---
 rtl/mem_access_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// Memory-stage access controller: issues dcache requests for EX/MEM ops, stalls
// until dhit, holds completed results for MEM/WB and owns the LL/SC link register.
module mem_access_ctrl (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        exmem_valid,
  input  logic        exmem_DRen,
  input  logic        exmem_DWen,
  input  logic        exmem_ll,
  input  logic        exmem_sc,
  input  logic [31:0] exmem_alu_out,
  input  logic [31:0] exmem_rdat2,
  input  logic        advance,
  input  logic        dhit,
  input  logic [31:0] dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output logic [31:0] dmemaddr,
  output logic [31:0] dmemstore,
  input  logic        snoop_inv,
  input  logic [31:0] snoop_addr,
  output logic        mem_stall,
  output logic [31:0] mem_rdata,
  output logic        sc_success,
  output logic        link_valid
);

  typedef enum logic [1:0] {IDLE, ACCESS, HOLD} state_t;

  state_t      state, state_next;
  logic [31:0] req_addr, req_data, hold_data;
  logic [31:2] link_addr;
  logic        req_rd, req_sc, req_ll;
  logic        op, snoop_hit, sc_fail, fail_now;
  logic        comp, comp_rd, comp_ll, comp_sc;
  logic [31:2] comp_addr;
  logic [31:0] comp_rdata;
  logic        load_req, load_hold;
  logic        addr_unused;

  // Link compares are word-granular, so the byte offset of a snoop is irrelevant.
  assign addr_unused = ^snoop_addr[1:0];

  assign op        = exmem_valid & (exmem_DRen | exmem_DWen);
  assign snoop_hit = snoop_inv & (snoop_addr[31:2] == link_addr);
  assign sc_fail   = exmem_sc & ~(link_valid & (link_addr == exmem_alu_out[31:2]) & ~snoop_hit);

  always_comb begin
    state_next = state;
    dmemREN    = 1'b0;
    dmemWEN    = 1'b0;
    dmemaddr   = '0;
    dmemstore  = '0;
    mem_stall  = 1'b0;
    mem_rdata  = '0;
    sc_success = 1'b0;
    comp       = 1'b0;
    comp_rd    = 1'b0;
    comp_ll    = 1'b0;
    comp_sc    = 1'b0;
    comp_addr  = exmem_alu_out[31:2];
    comp_rdata = '0;
    fail_now   = 1'b0;
    load_req   = 1'b0;
    load_hold  = 1'b0;
    case (state)
      IDLE: begin
        if (op) begin
          if (sc_fail) begin
            fail_now = 1'b1;
            if (!advance) begin
              state_next = HOLD;
              load_hold  = 1'b1;
            end
          end else begin
            dmemREN   = exmem_DRen;
            dmemWEN   = exmem_DWen;
            dmemaddr  = exmem_alu_out;
            dmemstore = exmem_rdat2;
            if (dhit) begin
              comp    = 1'b1;
              comp_rd = exmem_DRen;
              comp_ll = exmem_DRen & exmem_ll;
              comp_sc = exmem_DWen & exmem_sc;
              if (!advance) begin
                state_next = HOLD;
                load_hold  = 1'b1;
              end
            end else begin
              mem_stall  = 1'b1;
              state_next = ACCESS;
              load_req   = 1'b1;
            end
          end
        end
      end
      ACCESS: begin
        dmemREN   = req_rd;
        dmemWEN   = ~req_rd;
        dmemaddr  = req_addr;
        dmemstore = req_data;
        comp_addr = req_addr[31:2];
        if (dhit) begin
          comp    = 1'b1;
          comp_rd = req_rd;
          comp_ll = req_ll;
          comp_sc = req_sc;
          // A flushed op still finishes in the cache, but nobody waits for its result.
          if (advance || !exmem_valid) begin
            state_next = IDLE;
          end else begin
            state_next = HOLD;
            load_hold  = 1'b1;
          end
        end else begin
          mem_stall = 1'b1;
        end
      end
      HOLD: begin
        if (advance) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    if (comp) begin
      comp_rdata = comp_rd ? dmemload : (comp_sc ? 32'd1 : 32'd0);
      mem_rdata  = comp_rdata;
      sc_success = comp_sc;
    end
    if (state == HOLD) mem_rdata = hold_data;
    if (!nRST) begin
      dmemREN    = 1'b0;
      dmemWEN    = 1'b0;
      dmemaddr   = '0;
      dmemstore  = '0;
      mem_stall  = 1'b0;
      mem_rdata  = '0;
      sc_success = 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      req_addr   <= '0;
      req_data   <= '0;
      req_rd     <= 1'b0;
      req_ll     <= 1'b0;
      req_sc     <= 1'b0;
      hold_data  <= '0;
      link_valid <= 1'b0;
      link_addr  <= '0;
    end else begin
      if (load_req) begin
        req_addr <= exmem_alu_out;
        req_data <= exmem_rdat2;
        req_rd   <= exmem_DRen;
        req_ll   <= exmem_DRen & exmem_ll;
        req_sc   <= exmem_DWen & exmem_sc;
      end
      if (load_hold) hold_data <= comp_rdata;
      // A snoop to the word an LL is linking in the same cycle kills the new link.
      if (comp && comp_ll) begin
        link_addr  <= comp_addr;
        link_valid <= !(snoop_inv && (snoop_addr[31:2] == comp_addr));
      end else if (snoop_hit || fail_now || (comp && comp_sc) ||
                   (comp && !comp_rd && (comp_addr == link_addr))) begin
        link_valid <= 1'b0;
      end
    end
  end

endmodule
